// File: rtl/nand_gate_pkg.sv
// Shared definitions for the Hack gate library: default bus width and word type.
package nand_gate_pkg;

    localparam int HACK_WORD_W = 16;

    typedef logic [HACK_WORD_W-1:0] hack_word_t;

endpackage : nand_gate_pkg

// File: rtl/nand_gate_if.sv
// Operand/result bundle for nand_gate; the master drives operands, the slave returns results.
interface nand_gate_if
    import nand_gate_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             out_q_vld;

    modport master (
        output a,
        output b,
        output en,
        input  out,
        input  out_q,
        input  out_q_vld
    );

    modport slave (
        input  a,
        input  b,
        input  en,
        output out,
        output out_q,
        output out_q_vld
    );

endinterface : nand_gate_if

// File: rtl/nand_gate_cell.sv
// Single-bit NAND; the only place in the library where the NAND function itself is written.
module nand_cell
    import nand_gate_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = ~(a_i & b_i);

endmodule : nand_cell

// File: rtl/nand_gate.sv
// WIDTH-bit NAND built from nand_cell, with an optional enable-captured output register.
module nand_gate
    import nand_gate_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    nand_gate_if.slave  bus
);

    logic [WIDTH-1:0] nand_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nand_cell u_cell (
            .a_i (bus.a[i]),
            .b_i (bus.b[i]),
            .y_o (nand_w[i])
        );
    end

    assign bus.out = nand_w;

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] out_q_q;
        logic [WIDTH-1:0] out_q_d;
        logic             vld_q;
        logic             vld_d;

        // Valid is sticky: once a result is captured it stays set until reset.
        always_comb begin
            out_q_d = out_q_q;
            vld_d   = vld_q;
            if (bus.en) begin
                out_q_d = nand_w;
                vld_d   = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q_q <= '0;
                vld_q   <= 1'b0;
            end else begin
                out_q_q <= out_q_d;
                vld_q   <= vld_d;
            end
        end

        assign bus.out_q     = out_q_q;
        assign bus.out_q_vld = vld_q;
    end else begin : g_noreg
        // Clock, reset and enable have no function without the register stage.
        logic unused_ok;
        assign unused_ok     = ^{clk, rst_n, bus.en};
        assign bus.out_q     = '0;
        assign bus.out_q_vld = 1'b0;
    end

endmodule : nand_gate

// File: tb/tb_nand_gate.sv
// Bench for nand_gate: directed literal checks plus randomized traffic against a capture-log model.
module tb_nand_gate;
    import nand_gate_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       a1, b1;
    hack_word_t a16, b16;
    bit         chk_on = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nand_gate_if #(.WIDTH(1))           if1 ();
    nand_gate_if #(.WIDTH(HACK_WORD_W)) if16 ();
    nand_gate_if #(.WIDTH(HACK_WORD_W)) if0 ();

    assign if1.a  = a1;
    assign if1.b  = b1;
    assign if1.en = en;
    assign if16.a  = a16;
    assign if16.b  = b16;
    assign if16.en = en;
    assign if0.a  = a16;
    assign if0.b  = b16;
    assign if0.en = en;

    nand_gate #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    nand_gate #(.WIDTH(HACK_WORD_W), .REG_OUT(1'b1)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    nand_gate #(.WIDTH(HACK_WORD_W), .REG_OUT(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    // Reference NAND from the truth table: a bit is 0 only when both inputs are 1.
    function automatic hack_word_t nand_ref(hack_word_t a, hack_word_t b, int w);
        hack_word_t r = '0;
        for (int i = 0; i < w; i++)
            r[i] = ((int'(a[i]) + int'(b[i])) < 2);
        return r;
    endfunction

    task automatic chk(string name, hack_word_t act, hack_word_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Capture log: count of enabled edges since the last reset and the last captured words.
    int         cap_cnt;
    hack_word_t last1, last16;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cnt <= 0;
            last1   <= '0;
            last16  <= '0;
        end else if (en) begin
            cap_cnt <= cap_cnt + 1;
            last1   <= nand_ref(16'(a1), 16'(b1), 1);
            last16  <= nand_ref(a16, b16, HACK_WORD_W);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rnd_out1",    16'(if1.out),       nand_ref(16'(a1), 16'(b1), 1));
            chk("rnd_out16",   if16.out,           nand_ref(a16, b16, HACK_WORD_W));
            chk("rnd_out0",    if0.out,            nand_ref(a16, b16, HACK_WORD_W));
            chk("rnd_q1",      16'(if1.out_q),     (cap_cnt > 0) ? last1 : 16'h0);
            chk("rnd_vld1",    16'(if1.out_q_vld), 16'(cap_cnt > 0));
            chk("rnd_q16",     if16.out_q,         (cap_cnt > 0) ? last16 : 16'h0);
            chk("rnd_vld16",   16'(if16.out_q_vld), 16'(cap_cnt > 0));
            chk("rnd_q0",      if0.out_q,          16'h0);
            chk("rnd_vld0",    16'(if0.out_q_vld), 16'h0);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, required finish before 50000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] tt;
        tt    = 4'b0111;
        rst_n = 1'b0;
        en    = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a16 = '0; b16 = '0;

        // Reset held: combinational path live, registered outputs cleared.
        for (int i = 0; i < 4; i++) begin
            a1  = i[1]; b1 = i[0];
            a16 = hack_word_t'($urandom); b16 = hack_word_t'($urandom);
            en  = 1'b1;
            #1;
            chk("rst_out1",  16'(if1.out),  16'(tt[i]));
            chk("rst_out16", if16.out,      ~(a16 & b16));
            chk("rst_q16",   if16.out_q,    16'h0);
            chk("rst_vld1",  16'(if1.out_q_vld), 16'h0);
            chk("rst_vld16", 16'(if16.out_q_vld), 16'h0);
            @(posedge clk);
            #2;
        end
        en    = 1'b0;
        rst_n = 1'b1;

        // Single-bit truth table.
        for (int i = 0; i < 4; i++) begin
            a1 = i[1]; b1 = i[0];
            #1;
            chk("tt_out1", 16'(if1.out), 16'(tt[i]));
        end

        a16 = 16'hFFFF; b16 = 16'h00FF; #1;
        chk("w16_ff00", if16.out, 16'hFF00);
        a16 = 16'hAAAA; b16 = 16'h5555; #1;
        chk("w16_ffff", if16.out, 16'hFFFF);

        // No capture yet: en has been low since reset release.
        @(posedge clk); #1;
        chk("noen_vld1", 16'(if1.out_q_vld), 16'h0);

        #1;
        a1 = 1'b1; b1 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; en = 1'b1;
        @(posedge clk); #1;
        chk("cap_q1",   16'(if1.out_q),     16'h0);
        chk("cap_vld1", 16'(if1.out_q_vld), 16'h1);
        chk("cap_q16",  if16.out_q,         16'h0000);
        chk("cap_vld0", 16'(if0.out_q_vld), 16'h0);
        chk("cap_out0", if0.out,            16'h0000);
        en = 1'b0; a1 = 1'b0; a16 = 16'h0F0F;
        #1;
        chk("hold_out1", 16'(if1.out),   16'h1);
        chk("hold_q1",   16'(if1.out_q), 16'h0);
        @(posedge clk); #1;
        chk("hold_q1b",   16'(if1.out_q),     16'h0);
        chk("hold_vld1b", 16'(if1.out_q_vld), 16'h1);
        chk("hold_q16",   if16.out_q,         16'h0000);

        // Capture a nonzero word, then reset between edges.
        en = 1'b1;
        @(posedge clk); #1;
        chk("cap2_q16", if16.out_q, 16'hF0F0);
        en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_q16",   if16.out_q,          16'h0);
        chk("arst_vld16", 16'(if16.out_q_vld), 16'h0);
        chk("arst_vld1",  16'(if1.out_q_vld),  16'h0);
        en = 1'b1;
        @(posedge clk); #1;
        chk("arst_hold_vld", 16'(if16.out_q_vld), 16'h0);
        #1;
        en    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_noen_vld", 16'(if16.out_q_vld), 16'h0);

        // Randomized traffic with occasional asynchronous resets.
        #1;
        chk_on = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            a16 = hack_word_t'($urandom);
            b16 = hack_word_t'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 39) != 0);
        end
        @(posedge clk);
        #2;
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_nand_gate
